// File: rtl/hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller: load-use bubbles, redirect flushes,
//               memory-wait freeze with timeout fault, saturating perf counters.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_waitrequest,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state
);

    localparam int c_wait_w = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_wait_w-1:0] c_max_wait = c_wait_w'(MAX_WAIT);
    localparam logic [c_wait_w-1:0] c_wait_one = c_wait_w'(1);
    localparam logic [CNT_W-1:0]    c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    r_flush_count;

    logic w_lu;
    logic w_ms;
    logic w_front_en;
    logic w_back_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_in_pipe;

    assign w_lu = ex_memread && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));
    assign w_ms      = mem_req && mem_waitrequest;
    assign w_in_pipe = (r_state == S_RUN) || (r_state == S_MEM_WAIT);

    // Priority: reset/INIT > HALT > memory freeze > redirect > load-use.
    always_comb begin
        w_front_en   = 1'b0;
        w_back_en    = 1'b0;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        if (reset || (r_state == S_INIT)) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (r_state == S_HALT || w_ms) begin
            w_front_en = 1'b0;
        end else if (ex_redirect) begin
            w_front_en   = 1'b1;
            w_back_en    = 1'b1;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_lu) begin
            w_back_en    = 1'b1;
            w_idex_flush = 1'b1;
        end else begin
            w_front_en = 1'b1;
            w_back_en  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_INIT;
            r_wait_cnt     <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_in_pipe && !w_front_en && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
            if ((r_state == S_RUN) && w_ifid_flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + c_cnt_one;

            case (r_state)
                S_INIT: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= '0;
                end
                S_RUN: begin
                    if (w_ms) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= c_wait_one;
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                S_MEM_WAIT: begin
                    if (!w_ms) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_max_wait) begin
                        r_state    <= S_HALT;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wait_one;
                    end
                end
                default: begin
                    r_state    <= S_HALT;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign pc_en        = w_front_en;
    assign ifid_en      = w_front_en;
    assign idex_en      = w_back_en;
    assign exmem_en     = w_back_en;
    assign memwb_en     = w_back_en;
    assign ifid_flush   = w_ifid_flush;
    assign idex_flush   = w_idex_flush;
    assign fault        = (r_state == S_HALT);
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scenario and randomized bench for hazard_ctrl against a
//               rule-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int SAT      = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_memread, ex_redirect;
    logic             mem_req, mem_waitrequest;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, fault;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: spec state numbering, streak of consecutive ms cycles
    int m_state  = 0;
    int m_streak = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_waitrequest(mem_waitrequest),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fault(fault), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    function automatic logic [6:0] ctl_bus();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
    endfunction

    function automatic logic [6:0] exp_ctl();
        bit lu, ms;
        lu = ex_memread && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        ms = mem_req && mem_waitrequest;
        if (reset || m_state == 0) return 7'b00000_11;
        if (m_state == 3 || ms)    return 7'b00000_00;
        if (ex_redirect)           return 7'b11111_11;
        if (lu)                    return 7'b00111_01;
        return 7'b11111_00;
    endfunction

    function automatic logic [13:0] exp_regs();
        return {2'(m_state), (m_state == 3), 4'(m_stall), 4'(m_flush), 3'b000};
    endfunction

    function automatic logic [13:0] got_regs();
        return {state, fault, stall_cycles, flush_count, 3'b000};
    endfunction

    task automatic step();
        logic [6:0] e;
        int ns, nstreak, nstall, nflush;
        e = exp_ctl();
        ns = m_state; nstreak = m_streak; nstall = m_stall; nflush = m_flush;
        if (reset) begin
            ns = 0; nstreak = 0; nstall = 0; nflush = 0;
        end else begin
            if ((m_state == 1 || m_state == 2) && !e[6] && nstall < SAT) nstall++;
            if (m_state == 1 && e[1] && nflush < SAT) nflush++;
            if (m_state == 0) ns = 1;
            else if (m_state == 3) ns = 3;
            else if (mem_req && mem_waitrequest) begin
                nstreak++;
                ns = (nstreak > MAX_WAIT) ? 3 : 2;
            end else begin
                nstreak = 0;
                ns = 1;
            end
        end
        @(posedge clk);
        m_state = ns; m_streak = nstreak; m_stall = nstall; m_flush = nflush;
        #1;
    endtask

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_memread = 0; ex_redirect = 0;
        mem_req = 0; mem_waitrequest = 0;
    endtask

    task automatic set_lu();
        ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1;
        step(); step();
        reset = 0;
        step();
    endtask

    task automatic test_reset();
        logic [6:0] got;
        reset = 1;
        ex_redirect = 1; mem_req = 1; mem_waitrequest = 1;
        #2;
        got = ctl_bus();
        n_checks++;
        if (got !== 7'b00000_11) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", got, 7'b00000_11);
        end
        step();
        n_checks++;
        if (state !== 2'd0 || fault !== 1'b0 || stall_cycles !== 0 || flush_count !== 0) begin
            n_fail++;
            $display("FAIL reset_regs: got state=%0d fault=%b stall=%0d flush=%0d expected 0/0/0/0",
                     state, fault, stall_cycles, flush_count);
        end
        set_idle();
        reset = 0;
        #2;
        got = ctl_bus();
        n_checks++;
        if (got !== 7'b00000_11 || state !== 2'd0) begin
            n_fail++; $display("FAIL init_cycle: got ctl=%b state=%0d expected 0000011/0", got, state);
        end
        step();
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++; $display("FAIL init_to_run: got state=%0d expected 1", state);
        end
    endtask

    task automatic test_load_use();
        logic [6:0] got;
        do_reset();
        set_lu();
        #2;
        got = ctl_bus();
        n_checks++;
        if (got !== 7'b00111_01) begin
            n_fail++; $display("FAIL load_use_ctl: got %b expected %b", got, 7'b00111_01);
        end
        step();
        set_idle();
        #2;
        got = ctl_bus();
        n_checks++;
        if (got !== 7'b11111_00 || stall_cycles !== 4'd1) begin
            n_fail++; $display("FAIL load_use_after: got ctl=%b stall=%0d expected 1111100/1", got, stall_cycles);
        end
    endtask

    task automatic test_redirect_lu();
        logic [6:0] got;
        do_reset();
        set_lu();
        ex_redirect = 1;
        #2;
        got = ctl_bus();
        n_checks++;
        if (got !== 7'b11111_11) begin
            n_fail++; $display("FAIL redirect_ctl: got %b expected %b", got, 7'b11111_11);
        end
        step();
        set_idle();
        n_checks++;
        if (flush_count !== 4'd1 || stall_cycles !== 4'd0) begin
            n_fail++; $display("FAIL redirect_cnt: got flush=%0d stall=%0d expected 1/0", flush_count, stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        logic [6:0] got;
        do_reset();
        mem_req = 1; mem_waitrequest = 1;
        set_lu(); ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            got = ctl_bus();
            n_checks++;
            if (got !== 7'b00000_00 || state !== ((i == 0) ? 2'd1 : 2'd2)) begin
                n_fail++; $display("FAIL mem_wait_freeze[%0d]: got ctl=%b state=%0d expected 0000000/%0d",
                                   i, got, state, (i == 0) ? 1 : 2);
            end
            step();
        end
        set_idle();
        mem_req = 1;
        #2;
        got = ctl_bus();
        n_checks++;
        if (got !== 7'b11111_00 || state !== 2'd2) begin
            n_fail++; $display("FAIL mem_wait_release: got ctl=%b state=%0d expected 1111100/2", got, state);
        end
        step();
        set_idle();
        n_checks++;
        if (state !== 2'd1 || stall_cycles !== 4'd3) begin
            n_fail++; $display("FAIL mem_wait_after: got state=%0d stall=%0d expected 1/3", state, stall_cycles);
        end
    endtask

    task automatic test_timeout();
        int cycles;
        logic [6:0] got;
        do_reset();
        mem_req = 1; mem_waitrequest = 1;
        cycles = 0;
        while (state !== 2'd3 && cycles < 20) begin
            step();
            cycles++;
        end
        n_checks++;
        if (cycles != MAX_WAIT + 1 || fault !== 1'b1) begin
            n_fail++; $display("FAIL timeout_entry: got edges=%0d fault=%b expected %0d/1", cycles, fault, MAX_WAIT + 1);
        end
        set_idle();
        ex_redirect = 1;
        repeat (3) step();
        #2;
        got = ctl_bus();
        n_checks++;
        if (fault !== 1'b1 || state !== 2'd3 || got !== 7'b00000_00) begin
            n_fail++; $display("FAIL halt_sticky: got fault=%b state=%0d ctl=%b expected 1/3/0000000", fault, state, got);
        end
        set_idle();
        reset = 1;
        step();
        reset = 0;
        n_checks++;
        if (state !== 2'd0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset: got state=%0d fault=%b expected 0/0", state, fault);
        end
        step();
    endtask

    task automatic test_rd_zero();
        logic [6:0] got;
        do_reset();
        ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; id_rs2 = 0; id_use_rs2 = 1;
        #2;
        got = ctl_bus();
        n_checks++;
        if (got !== 7'b11111_00) begin
            n_fail++; $display("FAIL rd_zero_ctl: got %b expected %b", got, 7'b11111_00);
        end
        step();
        set_idle();
        n_checks++;
        if (stall_cycles !== 4'd0) begin
            n_fail++; $display("FAIL rd_zero_stall: got %0d expected 0", stall_cycles);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_lu();
        repeat (20) step();
        set_idle();
        n_checks++;
        if (stall_cycles !== 4'd15) begin
            n_fail++; $display("FAIL stall_saturate: got %0d expected 15", stall_cycles);
        end
        ex_redirect = 1;
        repeat (20) step();
        set_idle();
        n_checks++;
        if (flush_count !== 4'd15 || stall_cycles !== 4'd15) begin
            n_fail++; $display("FAIL flush_saturate: got flush=%0d stall=%0d expected 15/15", flush_count, stall_cycles);
        end
    endtask

    task automatic test_random();
        logic [6:0]  got, e;
        logic [13:0] gr, er;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(0, 39) == 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_memread      = 1'($urandom_range(0, 1));
            ex_redirect     = ($urandom_range(0, 5) == 0);
            mem_req         = 1'($urandom_range(0, 1));
            mem_waitrequest = ($urandom_range(0, 9) < 7);
            #2;
            got = ctl_bus();
            e   = exp_ctl();
            n_checks++;
            if (got !== e) begin
                n_fail++; $display("FAIL random_ctl[%0d]: got %b expected %b", i, got, e);
            end
            step();
            gr = got_regs();
            er = exp_regs();
            n_checks++;
            if (gr !== er) begin
                n_fail++; $display("FAIL random_regs[%0d]: got %h expected %h", i, gr, er);
            end
        end
        reset = 0;
        set_idle();
    endtask

    initial begin
        set_idle();
        reset = 1;
        step();
        test_reset();
        test_load_use();
        test_redirect_lu();
        test_mem_wait();
        test_timeout();
        test_rd_zero();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 255: maximum consecutive memory waitrequest cycles tolerated before fault.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-004 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1 / rs2
- ex_rd  in  5  destination register in EX
- ex_memread  in  1  EX instruction is a load
- ex_redirect  in  1  branch taken or jump resolved in EX
- mem_req  in  1  MEM stage drives an Avalon read/write this cycle
- mem_waitrequest  in  1  Avalon waitrequest
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  pipeline register enables
- ifid_flush, idex_flush  out  1  load a bubble (NOP) on the next edge
- fault  out  1  sticky memory-timeout fault
- stall_cycles  out  CNT_W  count of cycles with pc_en=0 in RUN or MEM_WAIT
- flush_count  out  CNT_W  count of redirect flushes issued
- state  out  2  FSM state: INIT=0, RUN=1, MEM_WAIT=2, HALT=3

Function
REQ-005 The FSM SHALL use the states INIT, RUN, MEM_WAIT and HALT; the state register and all counters SHALL be registered on clk.
REQ-006 The outputs SHALL be combinational decodes of the state and the inputs; the hazard response SHALL take effect in the same cycle, with zero latency.
REQ-007 The load-use signal lu SHALL equal ex_memread & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-008 The memory-stall signal ms SHALL equal mem_req & mem_waitrequest.
REQ-009 INIT, HALT, or reset high: all enables SHALL be 0; in INIT/reset ifid_flush=idex_flush=1, and in HALT both flushes SHALL be 0.
REQ-010 In RUN or MEM_WAIT, if ms=1: all enables=0 and both flushes=0, freezing the whole pipeline (ex_redirect and lu are ignored and re-evaluated when released).
REQ-011 Else if ex_redirect=1: all enables=1 and ifid_flush=idex_flush=1; redirect SHALL take priority over lu.
REQ-012 Else if lu=1: pc_en=0, ifid_en=0, idex_flush=1, and idex_en=exmem_en=memwb_en=1, giving exactly one bubble per detection.
REQ-013 Else: all enables=1 and both flushes=0.
REQ-014 Transitions: INIT->RUN unconditionally; RUN->MEM_WAIT when ms=1; MEM_WAIT->RUN when mem_waitrequest=0 or mem_req=0; MEM_WAIT->HALT when ms=1 and wait_cnt==MAX_WAIT; HALT stays in HALT until reset.
REQ-015 wait_cnt, an internal counter of width clog2(MAX_WAIT+1):
- loads 1 on RUN->MEM_WAIT;
- increments each MEM_WAIT cycle with ms=1;
- clears in every other state.
REQ-016 With a continuous waitrequest starting in RUN at cycle t0, the FSM SHALL enter HALT at t0+MAX_WAIT+1.
REQ-017 fault SHALL be 1 in HALT and 0 otherwise.
REQ-018 stall_cycles SHALL increment on each RUN/MEM_WAIT cycle with pc_en=0.
REQ-019 flush_count SHALL increment on each cycle where ifid_flush=1 in RUN.
REQ-020 Both counters SHALL saturate at all-ones and SHALL not wrap.
REQ-021 ex_rd=0 SHALL never produce a load-use stall.

Reset
REQ-022 While reset=1, on each clk edge: state<=INIT, wait_cnt<=0, stall_cycles<=0, flush_count<=0.
REQ-023 Reset asserted mid-MEM_WAIT or in HALT SHALL abort immediately; the first cycle after reset deasserts SHALL be INIT, with RUN following one cycle later.
REQ-024 After reset: state=0, fault=0, counters=0, all enables=0, both flushes=1.

Verification
REQ-025 Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cycles=1 after.
REQ-026 Redirect and load-use together: ex_redirect=1 with the lu conditions true -> pc_en=1, ifid_flush=idex_flush=1; flush_count increments by 1; stall_cycles unchanged.
REQ-027 Memory wait: mem_req=1 with waitrequest high for 3 cycles then low -> all enables 0 for 3 cycles, state=MEM_WAIT for 2, RUN after release; stall_cycles=3.
REQ-028 Timeout: MAX_WAIT=4 with waitrequest held high -> HALT and fault=1 on the 6th cycle; fault stays 1 until reset, then state=INIT and fault=0.
REQ-029 ex_rd=0 case: ex_memread=1, ex_rd=0, id_rs1=0, id_use_rs1=1 -> no stall, all enables=1.
REQ-030 Saturation: CNT_W=4 with 20 lu cycles -> stall_cycles=15.
